parity_frame_ctrl: RTL and testbench

PARITY_FRAME_CTRL -- requirements
Module: parity_frame_ctrl

---
 rtl/parity_frame_ctrl.sv | 135 +++++++++++++
 tb/tb_parity_frame_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl: serial frame receiver with parity check.
// Receives NDATA data bits LSB-first, then one parity bit. It reports the
// captured data, the parity result and frame/error counts.
// Optional feature macro: PARITY_ERR_COUNTER_EN enables the error counter.
// Without it, err_cnt is tied to zero and no counter register exists.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; start is only sampled here
// DATA   | shifting in NDATA data bits and accumulating their XOR
// PARITY | sampling the parity bit and latching the frame result
// DONE   | one-cycle done pulse, then back to IDLE
module parity_frame_ctrl #(
   parameter int NDATA      = 8,
   parameter int ODD_PARITY = 1
) (
   input  logic             clk_2,
   input  logic             reset,
   input  logic             start,
   input  logic             in_bit,
   output logic             busy,
   output logic             done,
   output logic             parity_ok,
   output logic [NDATA-1:0] data_out,
   output logic [7:0]       frame_cnt,
   output logic [7:0]       err_cnt,
   output logic [1:0]       state_dbg
);

   localparam int IW = (NDATA > 1) ? $clog2(NDATA) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NDATA - 1);
   localparam logic ODD_L = (ODD_PARITY != 0);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]       r_state;
   logic [IW-1:0]    r_idx;
   logic             r_acc;
   logic [NDATA-1:0] r_shift;
   logic             r_done;
   logic             r_ok;
   logic [NDATA-1:0] r_data;
   logic [7:0]       r_frame_cnt;
   logic             w_frame_ok;
   logic             w_frame_end;

   // in_bit is the parity bit while in PARITY
   assign w_frame_ok  = ((r_acc ^ in_bit) == ODD_L);
   assign w_frame_end = (r_state == S_PARITY);

   // FSM sequencing, bit index, data capture and parity accumulator
   always_ff @(posedge clk_2) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_acc   <= 1'b0;
         r_shift <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_DATA;
                  r_idx   <= '0;
                  r_acc   <= 1'b0;
               end
            end
            S_DATA: begin
               r_shift[r_idx] <= in_bit;
               r_acc          <= r_acc ^ in_bit;
               if (r_idx == LAST_IDX) begin
                  r_idx   <= '0;
                  r_state <= S_PARITY;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_PARITY: r_state <= S_DONE;
            S_DONE:   r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   // Frame results latch on entry to DONE and hold until the next frame ends
   always_ff @(posedge clk_2) begin
      if (reset) begin
         r_done <= 1'b0;
         r_ok   <= 1'b0;
         r_data <= '0;
      end else begin
         r_done <= w_frame_end;
         if (w_frame_end) begin
            r_ok   <= w_frame_ok;
            r_data <= r_shift;
         end
      end
   end

   // Saturating count of completed frames
   always_ff @(posedge clk_2) begin
      if (reset) begin
         r_frame_cnt <= 8'd0;
      end else if (w_frame_end && (r_frame_cnt != 8'hFF)) begin
         r_frame_cnt <= r_frame_cnt + 8'd1;
      end
   end

`ifdef PARITY_ERR_COUNTER_EN
   logic [7:0] r_err_cnt;

   // Saturating count of frames that failed the parity check
   always_ff @(posedge clk_2) begin
      if (reset) begin
         r_err_cnt <= 8'd0;
      end else if (w_frame_end && !w_frame_ok && (r_err_cnt != 8'hFF)) begin
         r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign err_cnt = r_err_cnt;
`else
   assign err_cnt = 8'd0;
`endif

   assign busy      = (r_state != S_IDLE);
   assign state_dbg = r_state;
   assign done      = r_done;
   assign parity_ok = r_ok;
   assign data_out  = r_data;
   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Testbench for parity_frame_ctrl: directed frames checked against a
// frame-level model every cycle, plus hand-computed literal expectations.
module tb_parity_frame_ctrl;

   localparam int NDATA = 8;
   localparam int ODD   = 1;
`ifdef PARITY_ERR_COUNTER_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic             clk_2  = 1'b0;
   logic             reset  = 1'b1;
   logic             start  = 1'b0;
   logic             in_bit = 1'b0;
   logic             busy;
   logic             done;
   logic             parity_ok;
   logic [NDATA-1:0] data_out;
   logic [7:0]       frame_cnt;
   logic [7:0]       err_cnt;
   logic [1:0]       state_dbg;

   parity_frame_ctrl #(.NDATA(NDATA), .ODD_PARITY(ODD)) dut (
      .clk_2     (clk_2),
      .reset     (reset),
      .start     (start),
      .in_bit    (in_bit),
      .busy      (busy),
      .done      (done),
      .parity_ok (parity_ok),
      .data_out  (data_out),
      .frame_cnt (frame_cnt),
      .err_cnt   (err_cnt),
      .state_dbg (state_dbg)
   );

   always #5 clk_2 = ~clk_2;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;
   int done_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame-level model: m_pos = cycles elapsed in the current frame
   // (0 idle, 1..NDATA collecting data, NDATA+1 parity, NDATA+2 done)
   int m_pos = 0;
   int m_bits[NDATA];
   int m_data = 0;
   int m_ok = 0;
   int m_fc = 0;
   int m_ec = 0;

   always @(posedge clk_2) begin
      int ones;
      int v;
      if (reset) begin
         m_pos = 0; m_data = 0; m_ok = 0; m_fc = 0; m_ec = 0;
      end else if (m_pos == 0) begin
         if (start) m_pos = 1;
      end else if (m_pos <= NDATA) begin
         m_bits[m_pos-1] = in_bit ? 1 : 0;
         m_pos++;
      end else if (m_pos == NDATA + 1) begin
         ones = in_bit ? 1 : 0;
         v = 0;
         for (int i = 0; i < NDATA; i++) begin
            ones += m_bits[i];
            v += m_bits[i] * (1 << i);
         end
         m_data = v;
         m_ok = ((ones % 2) == ODD) ? 1 : 0;
         m_fc = (m_fc < 255) ? m_fc + 1 : 255;
         if (ERR_EN && (m_ok == 0)) m_ec = (m_ec < 255) ? m_ec + 1 : 255;
         m_pos = NDATA + 2;
      end else begin
         m_pos = 0;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk_2) begin
      int exp_state;
      if (done === 1'b1) done_seen++;
      if (chk_en) begin
         exp_state = (m_pos == 0) ? 0 : (m_pos <= NDATA) ? 1 : (m_pos == NDATA + 1) ? 2 : 3;
         check("m_busy",      32'(busy),      32'(m_pos != 0));
         check("m_done",      32'(done),      32'(m_pos == NDATA + 2));
         check("m_state_dbg", 32'(state_dbg), 32'(exp_state));
         check("m_parity_ok", 32'(parity_ok), 32'(m_ok));
         check("m_data_out",  32'(data_out),  32'(m_data));
         check("m_frame_cnt", 32'(frame_cnt), 32'(m_fc));
         check("m_err_cnt",   32'(err_cnt),   32'(m_ec));
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      @(posedge clk_2); #1;
      reset = 1'b0;
   endtask

   // One frame: start pulse, NDATA data bits LSB-first, parity bit.
   // poke raises start during DATA and PARITY, which must be ignored.
   task automatic send_frame(input logic [NDATA-1:0] d, input logic p, input bit poke);
      @(posedge clk_2); #1;
      start = 1'b1;
      @(posedge clk_2); #1;               // edge 0
      start = 1'b0;
      for (int i = 0; i < NDATA; i++) begin
         in_bit = d[i];
         start  = poke && (i == 3);
         @(posedge clk_2); #1;            // edges 1..NDATA
      end
      check("done_before_parity", 32'(done), 32'd0);
      in_bit = p;
      start  = poke;
      @(posedge clk_2); #1;               // edge NDATA+1
      start  = 1'b0;
      in_bit = 1'b0;
      check("done_after_parity_edge", 32'(done), 32'd1);
      check("state_done", 32'(state_dbg), 32'd3);
      @(posedge clk_2); #1;               // back to IDLE
      check("done_one_cycle", 32'(done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int low_cnt;
      int done_edges[$];

      // Reset wins over start and in_bit
      reset = 1'b1; start = 1'b1; in_bit = 1'b1;
      repeat (2) @(posedge clk_2);
      #1;
      chk_en = 1'b1;
      check("rst_state",     32'(state_dbg), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_done",      32'(done),      32'd0);
      check("rst_data_out",  32'(data_out),  32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("rst_err_cnt",   32'(err_cnt),   32'd0);
      reset = 1'b0; start = 1'b0; in_bit = 1'b0;

      // Bits 1,0,1,1,0,0,0,0 with parity 0: odd parity holds
      d0 = done_seen;
      send_frame(8'h0D, 1'b0, 1'b0);
      check("a_data_out",  32'(data_out),  32'h0D);
      check("a_parity_ok", 32'(parity_ok), 32'd1);
      check("a_frame_cnt", 32'(frame_cnt), 32'd1);
      check("a_err_cnt",   32'(err_cnt),   32'd0);
      check("a_done_cnt",  32'(done_seen - d0), 32'd1);

      // Same data with parity 1: parity error
      do_reset();
      send_frame(8'h0D, 1'b1, 1'b0);
      check("b_parity_ok", 32'(parity_ok), 32'd0);
      check("b_err_cnt",   32'(err_cnt),   ERR_EN ? 32'd1 : 32'd0);
      check("b_frame_cnt", 32'(frame_cnt), 32'd1);
      // 0xFF has even weight, parity 1 makes it odd: good frame
      send_frame(8'hFF, 1'b1, 1'b0);
      check("b2_data_out",  32'(data_out),  32'hFF);
      check("b2_parity_ok", 32'(parity_ok), 32'd1);
      check("b2_frame_cnt", 32'(frame_cnt), 32'd2);
      check("b2_err_cnt",   32'(err_cnt),   ERR_EN ? 32'd1 : 32'd0);

      // start pulses during DATA and PARITY are ignored, nothing queued
      do_reset();
      d0 = done_seen;
      send_frame(8'h5A, 1'b1, 1'b1);
      repeat (3) @(posedge clk_2);
      #1;
      check("c_done_cnt",  32'(done_seen - d0), 32'd1);
      check("c_busy_idle", 32'(busy),      32'd0);
      check("c_data_out",  32'(data_out),  32'h5A);
      check("c_frame_cnt", 32'(frame_cnt), 32'd1);
      check("c_parity_ok", 32'(parity_ok), 32'd1);

      // Reset mid-frame after 4 data bits abandons the frame
      do_reset();
      send_frame(8'hC3, 1'b0, 1'b0);
      check("d_pre_frame_cnt", 32'(frame_cnt), 32'd1);
      @(posedge clk_2); #1;
      start = 1'b1;
      @(posedge clk_2); #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_bit = 1'b1;
         @(posedge clk_2); #1;
      end
      check("d_in_data", 32'(state_dbg), 32'd1);
      reset = 1'b1; start = 1'b1;
      @(posedge clk_2); #1;
      reset = 1'b0; start = 1'b0; in_bit = 1'b0;
      check("d_state",     32'(state_dbg), 32'd0);
      check("d_busy",      32'(busy),      32'd0);
      check("d_data_out",  32'(data_out),  32'd0);
      check("d_frame_cnt", 32'(frame_cnt), 32'd0);
      check("d_err_cnt",   32'(err_cnt),   32'd0);
      d0 = done_seen;
      repeat (15) @(posedge clk_2);
      #1;
      check("d_no_done", 32'(done_seen - d0), 32'd0);

      // start held high: 3 back-to-back frames, done after edges 9, 20, 31
      do_reset();
      start = 1'b1;
      low_cnt = 0;
      for (int e = 0; e < 33; e++) begin
         in_bit = 1'($urandom_range(0, 1));
         @(posedge clk_2); #1;
         if (done) done_edges.push_back(e);
         if (!busy && e < 31) low_cnt++;
      end
      start = 1'b0;
      check("e_done_count", 32'(done_edges.size()), 32'd3);
      if (done_edges.size() == 3) begin
         check("e_done0", 32'(done_edges[0]), 32'd9);
         check("e_done1", 32'(done_edges[1]), 32'd20);
         check("e_done2", 32'(done_edges[2]), 32'd31);
      end
      check("e_idle_gap", 32'(low_cnt), 32'd2);
      check("e_frame_cnt", 32'(frame_cnt), 32'd3);

      // 260 error frames back-to-back: both counters saturate at 255
      do_reset();
      d0 = done_seen;
      start = 1'b1;
      in_bit = 1'b0;
      repeat (260 * 11) @(posedge clk_2);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk_2);
      #1;
      check("f_done_cnt",  32'(done_seen - d0), 32'd260);
      check("f_frame_cnt", 32'(frame_cnt), 32'd255);
      check("f_err_cnt",   32'(err_cnt),   ERR_EN ? 32'd255 : 32'd0);
      check("f_parity_ok", 32'(parity_ok), 32'd0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
